// File: rtl/picc_defs_pkg.sv
// ---------------------------------------------------------------------------
// picc_defs : shared definitions for the ISO 14443-3A PICC state controller.
//   - card state codes (out_state), response select codes (out_resp_sel)
//   - scheduler codes, decoded command codes, default FDT values
//   - cmd_pick(): resolves simultaneous command strobes by priority
// Optional feature macro: RATS_SUPPORT_EN (adds PROT state and ATS response).
// ---------------------------------------------------------------------------
package picc_defs;

    // Frame delay times in clk cycles (1 clk = 4 carrier cycles)
    localparam int FDT1_DEFAULT  = 309;  // last received bit = 1 (1236/fc)
    localparam int FDT0_DEFAULT  = 293;  // last received bit = 0 (1172/fc)
    localparam int CNT_W_DEFAULT = 9;

    // Card states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READY  = 3'd1;
    localparam logic [2:0] ST_ACTIVE = 3'd2;
    localparam logic [2:0] ST_HALT   = 3'd3;
`ifdef RATS_SUPPORT_EN
    localparam logic [2:0] ST_PROT   = 3'd4;
`endif

    // Response frame selection
    localparam logic [2:0] RESP_NONE    = 3'd0;
    localparam logic [2:0] RESP_ATQA    = 3'd1;
    localparam logic [2:0] RESP_UID_CL1 = 3'd2;
    localparam logic [2:0] RESP_SAK     = 3'd3;
`ifdef RATS_SUPPORT_EN
    localparam logic [2:0] RESP_ATS     = 3'd4;
`endif

    // Response scheduler
    localparam logic [1:0] SCH_LISTEN = 2'd0;
    localparam logic [1:0] SCH_WAIT   = 2'd1;
    localparam logic [1:0] SCH_TX     = 2'd2;

    // Decoded command after priority resolution
    localparam logic [2:0] CMD_NONE = 3'd0;
    localparam logic [2:0] CMD_WUPA = 3'd1;
    localparam logic [2:0] CMD_REQA = 3'd2;
    localparam logic [2:0] CMD_SEL  = 3'd3;
    localparam logic [2:0] CMD_ANTC = 3'd4;
    localparam logic [2:0] CMD_HLTA = 3'd5;
    localparam logic [2:0] CMD_RATS = 3'd6;

    // Priority WUPA > REQA > SEL > ANTC > HLTA > RATS; lower strobes dropped
    function automatic logic [2:0] cmd_pick(
        input logic wupa, input logic reqa, input logic sel,
        input logic antc, input logic hlta, input logic rats
    );
        logic [2:0] cmd;
        if (wupa)      cmd = CMD_WUPA;
        else if (reqa) cmd = CMD_REQA;
        else if (sel)  cmd = CMD_SEL;
        else if (antc) cmd = CMD_ANTC;
        else if (hlta) cmd = CMD_HLTA;
        else if (rats) cmd = CMD_RATS;
        else           cmd = CMD_NONE;
        return cmd;
    endfunction

endpackage

// File: rtl/picc_state_ctrl_fdt_timer.sv
// ---------------------------------------------------------------------------
// fdt_timer : down-counter that times the frame delay before encoder start.
//   clk      : system clock
//   por_n    : synchronous active-low reset
//   clr      : synchronous clear (abort pending start)
//   load     : load load_val into the counter
//   load_val : initial count (FDT - 1)
//   en       : decrement while high
//   count    : current count
//   expire   : high in the cycle whose edge brings the count to 0
// ---------------------------------------------------------------------------
module fdt_timer #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             por_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;

    // Counter: clear has priority over load, load over decrement
    always_ff @(posedge clk) begin
        if (!por_n) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Flag the last decrement so the caller can register its start pulse
    // on the same edge the counter reaches zero
    assign expire = en && (cnt_r == CNT_ONE);
    assign count  = cnt_r;

endmodule

// File: rtl/picc_state_ctrl.sv
// ---------------------------------------------------------------------------
// picc_state_ctrl : ISO 14443-3A PICC card state machine and response
// scheduler between the Miller decoder and the Manchester encoder.
//   clk            : 3.39 MHz system clock
//   in_PoR         : synchronous active-low reset
//   in_field       : RF field present (low = field loss, forces IDLE)
//   in_REQA..RATS  : one-cycle end-of-frame command strobes
//   in_last_bit    : last decoded data bit, valid with the strobe
//   in_tx_busy     : encoder busy
//   out_state      : card state code
//   out_tx_start   : one-cycle encoder start pulse, exactly FDT after strobe
//   out_resp_sel   : response frame select
//   out_busy       : high while waiting for FDT or transmitting
// Optional feature macro: RATS_SUPPORT_EN (RATS in ACTIVE -> PROT, ATS).
// ---------------------------------------------------------------------------
module picc_state_ctrl
    import picc_defs::*;
#(
    parameter int FDT1  = FDT1_DEFAULT,
    parameter int FDT0  = FDT0_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       in_PoR,
    input  logic       in_field,
    input  logic       in_REQA,
    input  logic       in_WUPA,
    input  logic       in_ANTC,
    input  logic       in_SEL,
    input  logic       in_HLTA,
    input  logic       in_RATS,
    input  logic       in_last_bit,
    input  logic       in_tx_busy,
    output logic [2:0] out_state,
    output logic       out_tx_start,
    output logic [2:0] out_resp_sel,
    output logic       out_busy
);

    // Counter is loaded with FDT-1 on the strobe edge so the start pulse
    // lands exactly FDT clocks after the strobe was raised
    localparam logic [CNT_W-1:0] LOAD1 = CNT_W'(FDT1 - 1);
    localparam logic [CNT_W-1:0] LOAD0 = CNT_W'(FDT0 - 1);

    logic [2:0]       state_r, state_nx_s;
    logic [1:0]       sched_r, sched_nx_s;
    logic [2:0]       resp_r, resp_nx_s;
    logic             tx_start_r, tx_start_nx_s;
    logic             busy_r;
    logic             seen_busy_r, seen_busy_nx_s;
    logic [2:0]       cmd_s;
    logic             load_s, clr_s, en_s, expire_s;
    logic [CNT_W-1:0] count_s;

    assign cmd_s = cmd_pick(in_WUPA, in_REQA, in_SEL, in_ANTC, in_HLTA, in_RATS);
    assign en_s  = (sched_r == SCH_WAIT);

    fdt_timer #(.CNT_W(CNT_W)) u_fdt_timer (
        .clk      (clk),
        .por_n    (in_PoR),
        .clr      (clr_s),
        .load     (load_s),
        .load_val (in_last_bit ? LOAD1 : LOAD0),
        .en       (en_s),
        .count    (count_s),
        .expire   (expire_s)
    );

    // Next-state logic for card FSM and response scheduler
    always_comb begin
        state_nx_s     = state_r;
        sched_nx_s     = sched_r;
        resp_nx_s      = resp_r;
        tx_start_nx_s  = 1'b0;
        seen_busy_nx_s = seen_busy_r;
        load_s         = 1'b0;
        clr_s          = 1'b0;
        if (!in_field) begin
            state_nx_s     = ST_IDLE;
            sched_nx_s     = SCH_LISTEN;
            resp_nx_s      = RESP_NONE;
            seen_busy_nx_s = 1'b0;
            clr_s          = 1'b1;
        end else begin
            case (sched_r)
                SCH_LISTEN: begin
                    resp_nx_s = RESP_NONE;
                    case (state_r)
                        ST_IDLE: begin
                            if ((cmd_s == CMD_WUPA) || (cmd_s == CMD_REQA)) begin
                                state_nx_s = ST_READY;
                                resp_nx_s  = RESP_ATQA;
                            end else begin
                                state_nx_s = ST_IDLE;
                            end
                        end
                        ST_READY: begin
                            if (cmd_s == CMD_NONE) begin
                                state_nx_s = ST_READY;
                            end else if (cmd_s == CMD_ANTC) begin
                                state_nx_s = ST_READY;
                                resp_nx_s  = RESP_UID_CL1;
                            end else if (cmd_s == CMD_SEL) begin
                                state_nx_s = ST_ACTIVE;
                                resp_nx_s  = RESP_SAK;
                            end else begin
                                state_nx_s = ST_IDLE;
                            end
                        end
                        ST_ACTIVE: begin
                            if (cmd_s == CMD_NONE) begin
                                state_nx_s = ST_ACTIVE;
                            end else if (cmd_s == CMD_HLTA) begin
                                state_nx_s = ST_HALT;
                            end
`ifdef RATS_SUPPORT_EN
                            else if (cmd_s == CMD_RATS) begin
                                state_nx_s = ST_PROT;
                                resp_nx_s  = RESP_ATS;
                            end
`endif
                            else begin
                                state_nx_s = ST_IDLE;
                            end
                        end
                        ST_HALT: begin
                            if (cmd_s == CMD_WUPA) begin
                                state_nx_s = ST_READY;
                                resp_nx_s  = RESP_ATQA;
                            end else begin
                                state_nx_s = ST_HALT;
                            end
                        end
`ifdef RATS_SUPPORT_EN
                        ST_PROT: begin
                            state_nx_s = ST_PROT;
                        end
`endif
                        default: begin
                            state_nx_s = ST_IDLE;
                        end
                    endcase
                    if (resp_nx_s != RESP_NONE) begin
                        sched_nx_s = SCH_WAIT;
                        load_s     = 1'b1;
                    end else begin
                        sched_nx_s = SCH_LISTEN;
                    end
                end
                SCH_WAIT: begin
                    if (expire_s) begin
                        tx_start_nx_s  = 1'b1;
                        sched_nx_s     = SCH_TX;
                        seen_busy_nx_s = 1'b0;
                    end else begin
                        sched_nx_s = SCH_WAIT;
                    end
                end
                SCH_TX: begin
                    // Leave only after the encoder has actually started and finished
                    if (in_tx_busy) begin
                        seen_busy_nx_s = 1'b1;
                    end else if (seen_busy_r) begin
                        sched_nx_s     = SCH_LISTEN;
                        resp_nx_s      = RESP_NONE;
                        seen_busy_nx_s = 1'b0;
                    end else begin
                        sched_nx_s = SCH_TX;
                    end
                end
                default: begin
                    sched_nx_s = SCH_LISTEN;
                    resp_nx_s  = RESP_NONE;
                    clr_s      = 1'b1;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!in_PoR) begin
            state_r     <= ST_IDLE;
            sched_r     <= SCH_LISTEN;
            resp_r      <= RESP_NONE;
            tx_start_r  <= 1'b0;
            busy_r      <= 1'b0;
            seen_busy_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            sched_r     <= sched_nx_s;
            resp_r      <= resp_nx_s;
            tx_start_r  <= tx_start_nx_s;
            busy_r      <= (sched_nx_s != SCH_LISTEN);
            seen_busy_r <= seen_busy_nx_s;
        end
    end

    assign out_state    = state_r;
    assign out_tx_start = tx_start_r;
    assign out_resp_sel = resp_r;
    assign out_busy     = busy_r;

    logic unused_s;
    assign unused_s = ^count_s;

endmodule

// File: tb/tb_picc_state_ctrl.sv
module tb_picc_state_ctrl;

    localparam int FDT1 = 309;
    localparam int FDT0 = 293;
    localparam int ENC_LEN = 100;

    // Mask bit order: {WUPA, REQA, SEL, ANTC, HLTA, RATS}
    localparam logic [5:0] M_WUPA = 6'b100000;
    localparam logic [5:0] M_REQA = 6'b010000;
    localparam logic [5:0] M_SEL  = 6'b001000;
    localparam logic [5:0] M_ANTC = 6'b000100;
    localparam logic [5:0] M_HLTA = 6'b000010;
    localparam logic [5:0] M_RATS = 6'b000001;

    logic       clk = 1'b0;
    logic       in_PoR = 1'b0;
    logic       in_field = 1'b1;
    logic       in_REQA = 1'b0, in_WUPA = 1'b0, in_ANTC = 1'b0;
    logic       in_SEL = 1'b0, in_HLTA = 1'b0, in_RATS = 1'b0;
    logic       in_last_bit = 1'b0;
    logic       in_tx_busy = 1'b0;
    logic [2:0] out_state;
    logic       out_tx_start;
    logic [2:0] out_resp_sel;
    logic       out_busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int resp;
    } exp_t;
    exp_t sb[$];

    picc_state_ctrl #(.FDT1(FDT1), .FDT0(FDT0), .CNT_W(9)) dut (
        .clk          (clk),
        .in_PoR       (in_PoR),
        .in_field     (in_field),
        .in_REQA      (in_REQA),
        .in_WUPA      (in_WUPA),
        .in_ANTC      (in_ANTC),
        .in_SEL       (in_SEL),
        .in_HLTA      (in_HLTA),
        .in_RATS      (in_RATS),
        .in_last_bit  (in_last_bit),
        .in_tx_busy   (in_tx_busy),
        .out_state    (out_state),
        .out_tx_start (out_tx_start),
        .out_resp_sel (out_resp_sel),
        .out_busy     (out_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every start pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (out_tx_start) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx_start at cyc %0d: got pulse, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tx_cycle", cyc, e.cyc);
                chk("tx_resp", int'(out_resp_sel), e.resp);
            end
        end
    end

    // Encoder model: busy rises one clk after start, lasts ENC_LEN clk
    initial begin
        forever begin
            @(negedge clk);
            if (out_tx_start) begin
                @(negedge clk);
                in_tx_busy = 1'b1;
                repeat (ENC_LEN) @(negedge clk);
                in_tx_busy = 1'b0;
            end
        end
    end

    task automatic pulse(input logic [5:0] m, input logic lb);
        {in_WUPA, in_REQA, in_SEL, in_ANTC, in_HLTA, in_RATS} = m;
        in_last_bit = lb;
        @(negedge clk);
        {in_WUPA, in_REQA, in_SEL, in_ANTC, in_HLTA, in_RATS} = 6'b000000;
    endtask

    // Issue a strobe; optionally book the expected start, then check state/resp/busy
    task automatic send(input logic [5:0] m, input logic lb, input int er,
                        input int es, input bit push);
        exp_t e;
        if (push) begin
            e.cyc  = cyc + (lb ? FDT1 : FDT0);
            e.resp = er;
            sb.push_back(e);
        end
        pulse(m, lb);
        chk("state", int'(out_state), es);
        chk("resp_sel", int'(out_resp_sel), er);
        chk("busy", int'(out_busy), (er != 0) ? 1 : 0);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (out_busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(out_busy), 0);
        chk("resp_cleared", int'(out_resp_sel), 0);
    endtask

    initial begin
        bit got;
        repeat (3) @(negedge clk);
        in_PoR = 1'b1;
        @(negedge clk);
        chk("rst_state", int'(out_state), 0);
        chk("rst_resp", int'(out_resp_sel), 0);
        chk("rst_busy", int'(out_busy), 0);
        chk("rst_tx", int'(out_tx_start), 0);

        // REQA, last bit 1 -> READY, ATQA, FDT1
        send(M_REQA, 1'b1, 1, 1, 1'b1);
        wait_idle(800);
        // Back-to-back: ANTC on the first LISTEN cycle, last bit 0
        send(M_ANTC, 1'b0, 2, 1, 1'b1);
        wait_idle(800);
        send(M_SEL, 1'b1, 3, 2, 1'b1);
        wait_idle(800);
        send(M_HLTA, 1'b1, 0, 3, 1'b0);
        repeat (3) @(negedge clk);
        send(M_REQA, 1'b1, 0, 3, 1'b0);
        send(M_WUPA, 1'b0, 1, 1, 1'b1);
        wait_idle(800);

        // READY + HLTA is invalid -> IDLE; then simultaneous strobes
        send(M_HLTA, 1'b0, 0, 0, 1'b0);
        send(M_WUPA | M_REQA | M_HLTA, 1'b1, 1, 1, 1'b1);
        wait_idle(800);

        // Strobe during WAIT is ignored
        send(M_ANTC, 1'b1, 2, 1, 1'b1);
        repeat (98) @(negedge clk);
        pulse(M_SEL, 1'b0);
        chk("wait_ignore_state", int'(out_state), 1);
        chk("wait_ignore_resp", int'(out_resp_sel), 2);
        wait_idle(800);

        // Field loss during WAIT aborts the start
        send(M_ANTC, 1'b0, 2, 1, 1'b0);
        repeat (148) @(negedge clk);
        in_field = 1'b0;
        @(negedge clk);
        in_field = 1'b1;
        chk("field_state", int'(out_state), 0);
        chk("field_resp", int'(out_resp_sel), 0);
        chk("field_busy", int'(out_busy), 0);
        repeat (200) @(negedge clk);

        // Reset during TX
        send(M_REQA, 1'b0, 1, 1, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (out_tx_start) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("tx_seen", int'(got), 1);
        repeat (5) @(negedge clk);
        in_PoR = 1'b0;
        @(negedge clk);
        in_PoR = 1'b1;
        chk("por_tx_state", int'(out_state), 0);
        chk("por_tx_resp", int'(out_resp_sel), 0);
        chk("por_tx_busy", int'(out_busy), 0);
        chk("por_tx_start", int'(out_tx_start), 0);
        repeat (120) @(negedge clk);

        // ACTIVE + RATS
        send(M_REQA, 1'b1, 1, 1, 1'b1);
        wait_idle(800);
        send(M_SEL, 1'b1, 3, 2, 1'b1);
        wait_idle(800);
`ifdef RATS_SUPPORT_EN
        send(M_RATS, 1'b1, 4, 4, 1'b1);
        wait_idle(800);
        send(M_REQA, 1'b1, 0, 4, 1'b0);
`else
        send(M_RATS, 1'b1, 0, 0, 1'b0);
`endif
        repeat (350) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
